// File: rtl/reg_dep_pkg.sv
// Shared widths and types for the register dependency scheduler.
// Optional macro REG_DEP_COMMIT_BYPASS_EN lives in reg_dep_lookup.
package reg_dep_pkg;

    localparam int ROB_IDX_W = 3;
    localparam int NREG      = 32;
    localparam int REG_ID_W  = 5;
    localparam int XLEN      = 32;

    typedef logic [REG_ID_W-1:0]  reg_id_t;
    typedef logic [ROB_IDX_W-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]      xlen_t;
    typedef logic [NREG-1:0][ROB_IDX_W-1:0] tag_tbl_t;

endpackage

// File: rtl/reg_dep_lookup.sv
// Per-source-operand dependency lookup producing next-cycle busy/tag/forward.
// REG_DEP_COMMIT_BYPASS_EN: a same-cycle clearing commit is forwarded.
module reg_dep_lookup
    import reg_dep_pkg::*;
(
    input  logic [NREG-1:0] i_busy,
    input  tag_tbl_t        i_tag,
    input  reg_id_t         i_q_id,
    input  logic            i_commit_valid,
    input  reg_id_t         i_commit_rd,
    input  rob_tag_t        i_commit_rob_id,
    input  xlen_t           i_commit_val,
    output logic            o_busy,
    output rob_tag_t        o_rob_id,
    output logic            o_fwd_valid,
    output xlen_t           o_fwd_val
);

`ifdef REG_DEP_COMMIT_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic w_hit;
    logic w_clr;
    logic w_fwd;

    always_comb begin
        w_hit = (i_q_id != '0) && i_busy[i_q_id];
        // A commit only retires the pending write if it is the latest producer.
        w_clr = i_commit_valid
             && (i_commit_rd == i_q_id)
             && (i_tag[i_q_id] == i_commit_rob_id);
        w_fwd       = w_hit && w_clr && BYPASS;
        o_busy      = w_hit && !w_fwd;
        o_rob_id    = o_busy ? i_tag[i_q_id] : '0;
        o_fwd_valid = w_fwd;
        o_fwd_val   = i_commit_val & {XLEN{w_fwd}};
    end

endmodule

// File: rtl/reg_dep_scheduler.sv
// Architectural register status table: busy/tag tracking, RF sequencing.
// Optional macro REG_DEP_COMMIT_BYPASS_EN enables commit-to-query forwarding.
module reg_dep_scheduler
    import reg_dep_pkg::*;
(
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush_pipline,
    input  logic     issue_valid,
    input  reg_id_t  issue_rd,
    input  rob_tag_t issue_rob_id,
    input  logic     q_rs1_valid,
    input  reg_id_t  q_rs1_id,
    input  logic     q_rs2_valid,
    input  reg_id_t  q_rs2_id,
    input  logic     commit_valid,
    input  reg_id_t  commit_rd,
    input  rob_tag_t commit_rob_id,
    input  xlen_t    commit_val,
    output logic     rf_rs1_rd_en,
    output reg_id_t  rf_rs1_id,
    output logic     rf_rs2_rd_en,
    output reg_id_t  rf_rs2_id,
    output logic     rf_wr_en,
    output reg_id_t  rf_wr_id,
    output xlen_t    rf_wr_val,
    output logic     rs1_busy,
    output rob_tag_t rs1_rob_id,
    output logic     rs2_busy,
    output rob_tag_t rs2_rob_id,
    output logic     rs1_fwd_valid,
    output xlen_t    rs1_fwd_val,
    output logic     rs2_fwd_valid,
    output xlen_t    rs2_fwd_val
);

    logic [NREG-1:0] r_busy;
    tag_tbl_t        r_tag;

    logic     w_rs1_busy;
    rob_tag_t w_rs1_rob_id;
    logic     w_rs1_fwd_valid;
    xlen_t    w_rs1_fwd_val;
    logic     w_rs2_busy;
    rob_tag_t w_rs2_rob_id;
    logic     w_rs2_fwd_valid;
    xlen_t    w_rs2_fwd_val;
    logic     w_commit_clr;
    logic     w_issue_set;

    always_comb begin
        rf_rs1_rd_en = q_rs1_valid & rdy_in;
        rf_rs1_id    = rdy_in ? q_rs1_id : '0;
        rf_rs2_rd_en = q_rs2_valid & rdy_in;
        rf_rs2_id    = rdy_in ? q_rs2_id : '0;
        rf_wr_en     = commit_valid & rdy_in & (commit_rd != '0);
        rf_wr_id     = rdy_in ? commit_rd : '0;
        rf_wr_val    = rdy_in ? commit_val : '0;
        w_commit_clr = commit_valid && (commit_rd != '0)
                    && (r_tag[commit_rd] == commit_rob_id);
        w_issue_set  = issue_valid && (issue_rd != '0);
    end

    reg_dep_lookup u_rs1 (
        .i_busy          (r_busy),
        .i_tag           (r_tag),
        .i_q_id          (q_rs1_id),
        .i_commit_valid  (commit_valid),
        .i_commit_rd     (commit_rd),
        .i_commit_rob_id (commit_rob_id),
        .i_commit_val    (commit_val),
        .o_busy          (w_rs1_busy),
        .o_rob_id        (w_rs1_rob_id),
        .o_fwd_valid     (w_rs1_fwd_valid),
        .o_fwd_val       (w_rs1_fwd_val)
    );

    reg_dep_lookup u_rs2 (
        .i_busy          (r_busy),
        .i_tag           (r_tag),
        .i_q_id          (q_rs2_id),
        .i_commit_valid  (commit_valid),
        .i_commit_rd     (commit_rd),
        .i_commit_rob_id (commit_rob_id),
        .i_commit_val    (commit_val),
        .o_busy          (w_rs2_busy),
        .o_rob_id        (w_rs2_rob_id),
        .o_fwd_valid     (w_rs2_fwd_valid),
        .o_fwd_val       (w_rs2_fwd_val)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_busy        <= '0;
            r_tag         <= '0;
            rs1_busy      <= 1'b0;
            rs1_rob_id    <= '0;
            rs1_fwd_valid <= 1'b0;
            rs1_fwd_val   <= '0;
            rs2_busy      <= 1'b0;
            rs2_rob_id    <= '0;
            rs2_fwd_valid <= 1'b0;
            rs2_fwd_val   <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                r_busy <= '0;
            end else begin
                // Issue is applied after commit so it wins on a collision.
                if (w_commit_clr) r_busy[commit_rd] <= 1'b0;
                if (w_issue_set) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_tag[issue_rd]  <= issue_rob_id;
                end
            end
            if (q_rs1_valid) begin
                rs1_busy      <= w_rs1_busy;
                rs1_rob_id    <= w_rs1_rob_id;
                rs1_fwd_valid <= w_rs1_fwd_valid;
                rs1_fwd_val   <= w_rs1_fwd_val;
            end
            if (q_rs2_valid) begin
                rs2_busy      <= w_rs2_busy;
                rs2_rob_id    <= w_rs2_rob_id;
                rs2_fwd_valid <= w_rs2_fwd_valid;
                rs2_fwd_val   <= w_rs2_fwd_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_dep_scheduler.sv
// Directed self-checking bench for reg_dep_scheduler.
// Expectations follow REG_DEP_COMMIT_BYPASS_EN when it is defined.
module tb_reg_dep_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [2:0]  issue_rob_id;
    logic        q_rs1_valid;
    logic [4:0]  q_rs1_id;
    logic        q_rs2_valid;
    logic [4:0]  q_rs2_id;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [2:0]  commit_rob_id;
    logic [31:0] commit_val;
    logic        rf_rs1_rd_en;
    logic [4:0]  rf_rs1_id;
    logic        rf_rs2_rd_en;
    logic [4:0]  rf_rs2_id;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_id;
    logic [31:0] rf_wr_val;
    logic        rs1_busy;
    logic [2:0]  rs1_rob_id;
    logic        rs2_busy;
    logic [2:0]  rs2_rob_id;
    logic        rs1_fwd_valid;
    logic [31:0] rs1_fwd_val;
    logic        rs2_fwd_valid;
    logic [31:0] rs2_fwd_val;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    reg_dep_scheduler dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .flush_pipline (flush_pipline),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rob_id  (issue_rob_id),
        .q_rs1_valid   (q_rs1_valid),
        .q_rs1_id      (q_rs1_id),
        .q_rs2_valid   (q_rs2_valid),
        .q_rs2_id      (q_rs2_id),
        .commit_valid  (commit_valid),
        .commit_rd     (commit_rd),
        .commit_rob_id (commit_rob_id),
        .commit_val    (commit_val),
        .rf_rs1_rd_en  (rf_rs1_rd_en),
        .rf_rs1_id     (rf_rs1_id),
        .rf_rs2_rd_en  (rf_rs2_rd_en),
        .rf_rs2_id     (rf_rs2_id),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_id      (rf_wr_id),
        .rf_wr_val     (rf_wr_val),
        .rs1_busy      (rs1_busy),
        .rs1_rob_id    (rs1_rob_id),
        .rs2_busy      (rs2_busy),
        .rs2_rob_id    (rs2_rob_id),
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs1_fwd_val   (rs1_fwd_val),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs2_fwd_val   (rs2_fwd_val)
    );

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        flush_pipline = 1'b0;
        issue_valid   = 1'b0;
        issue_rd      = '0;
        issue_rob_id  = '0;
        q_rs1_valid   = 1'b0;
        q_rs1_id      = '0;
        q_rs2_valid   = 1'b0;
        q_rs2_id      = '0;
        commit_valid  = 1'b0;
        commit_rd     = '0;
        commit_rob_id = '0;
        commit_val    = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] tag);
        issue_valid  = 1'b1;
        issue_rd     = rd;
        issue_rob_id = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [2:0] tag,
                          input logic [31:0] val);
        commit_valid  = 1'b1;
        commit_rd     = rd;
        commit_rob_id = tag;
        commit_val    = val;
    endtask

    task automatic q1(input logic [4:0] id);
        q_rs1_valid = 1'b1;
        q_rs1_id    = id;
    endtask

    task automatic q2(input logic [4:0] id);
        q_rs2_valid = 1'b1;
        q_rs2_id    = id;
    endtask

    initial begin
        idle();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        step();
        step();
        rst_in = 1'b1;
        chk("rst_rs1_busy", rs1_busy, 0);
        chk("rst_rs1_tag", rs1_rob_id, 0);
        chk("rst_rs2_busy", rs2_busy, 0);
        chk("rst_rs1_fwd", rs1_fwd_valid, 0);

        // Fresh query of x5
        q1(5);
        #1;
        chk("rd_en_x5", rf_rs1_rd_en, 1);
        chk("rd_id_x5", rf_rs1_id, 5);
        step();
        idle();
        chk("x5_idle_busy", rs1_busy, 0);
        chk("x5_idle_tag", rs1_rob_id, 0);

        // Issue / query / commit x5
        issue(5, 3);
        step();
        idle();
        q1(5);
        step();
        idle();
        chk("x5_busy", rs1_busy, 1);
        chk("x5_tag", rs1_rob_id, 3);
        step();
        chk("x5_hold_busy", rs1_busy, 1);
        commit(5, 3, 32'hDEAD);
        #1;
        chk("wr_en_x5", rf_wr_en, 1);
        chk("wr_id_x5", rf_wr_id, 5);
        chk("wr_val_x5", rf_wr_val, 32'hDEAD);
        step();
        idle();
        q1(5);
        step();
        idle();
        chk("x5_clear", rs1_busy, 0);

        // Stale commit must not clear a newer producer
        issue(7, 1);
        step();
        issue(7, 4);
        step();
        idle();
        commit(7, 1, 32'h1);
        step();
        idle();
        q2(7);
        step();
        idle();
        chk("x7_busy", rs2_busy, 1);
        chk("x7_tag4", rs2_rob_id, 4);
        issue(7, 6);
        commit(7, 4, 32'h2);
        step();
        idle();
        q2(7);
        step();
        idle();
        chk("x7_issue_wins", rs2_busy, 1);
        chk("x7_tag6", rs2_rob_id, 6);

        // Query colliding with a clearing commit
        issue(2, 2);
        step();
        idle();
        q1(2);
        commit(2, 2, 32'h55);
        step();
        idle();
`ifdef REG_DEP_COMMIT_BYPASS_EN
        chk("x2_byp_busy", rs1_busy, 0);
        chk("x2_byp_fwd", rs1_fwd_valid, 1);
        chk("x2_byp_val", rs1_fwd_val, 32'h55);
`else
        chk("x2_nobyp_busy", rs1_busy, 1);
        chk("x2_nobyp_tag", rs1_rob_id, 2);
        chk("x2_nobyp_fwd", rs1_fwd_valid, 0);
`endif
        q1(2);
        step();
        idle();
        chk("x2_after", rs1_busy, 0);
        chk("x2_after_fwd", rs1_fwd_valid, 0);

        // Flush with same-cycle issue and commit
        issue(1, 1);
        step();
        issue(3, 3);
        step();
        issue(9, 5);
        step();
        idle();
        flush_pipline = 1'b1;
        issue(4, 7);
        commit(1, 1, 32'h11);
        #1;
        chk("flush_wr_en", rf_wr_en, 1);
        chk("flush_wr_id", rf_wr_id, 1);
        step();
        idle();
        q1(1);
        q2(3);
        step();
        idle();
        chk("flush_x1", rs1_busy, 0);
        chk("flush_x3", rs2_busy, 0);
        q1(4);
        q2(9);
        step();
        idle();
        chk("flush_x4", rs1_busy, 0);
        chk("flush_x9", rs2_busy, 0);
        q1(7);
        step();
        idle();
        chk("flush_x7", rs1_busy, 0);

        // x0 is never tracked or written
        issue(0, 5);
        step();
        idle();
        q1(0);
        step();
        idle();
        chk("x0_busy", rs1_busy, 0);
        chk("x0_tag", rs1_rob_id, 0);
        chk("x0_fwd", rs1_fwd_valid, 0);
        commit(0, 5, 32'h77);
        #1;
        chk("x0_wr_en", rf_wr_en, 0);
        step();
        idle();

        // Stall freezes everything
        issue(6, 2);
        step();
        idle();
        q1(6);
        step();
        idle();
        chk("x6_busy", rs1_busy, 1);
        chk("x6_tag", rs1_rob_id, 2);
        rdy_in = 1'b0;
        issue(10, 3);
        q1(10);
        commit(6, 2, 32'h1234);
        #1;
        chk("stall_rd_en", rf_rs1_rd_en, 0);
        chk("stall_rd_id", rf_rs1_id, 0);
        chk("stall_wr_en", rf_wr_en, 0);
        chk("stall_wr_val", rf_wr_val, 0);
        step();
        idle();
        rdy_in = 1'b1;
        chk("stall_hold_busy", rs1_busy, 1);
        chk("stall_hold_tag", rs1_rob_id, 2);
        q1(10);
        q2(6);
        step();
        idle();
        chk("stall_x10", rs1_busy, 0);
        chk("stall_x6", rs2_busy, 1);
        chk("stall_x6_tag", rs2_rob_id, 2);

        // Reset mid-stream
        issue(12, 1);
        step();
        idle();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        chk("rst2_rs2_busy", rs2_busy, 0);
        chk("rst2_rs2_tag", rs2_rob_id, 0);
        q1(12);
        q2(6);
        step();
        idle();
        chk("rst2_x12", rs1_busy, 0);
        chk("rst2_x6", rs2_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dep_scheduler.md
Name: reg_dep_scheduler

Overview:
Register-status controller that sequences the architectural register file in the out-of-order core.
- Tracks, per architectural register, whether a pending ROB entry will write it, and that entry's tag.
- Drives the register file's read enables and its single write port from ROB commits.
- Returns registered dependency info aligned with the register file's 1-cycle read data, so issue sees value, busy flag and producer tag in the same cycle.

Parameters:
- ROB_IDX_W, 3, width of ROB tag (8-entry ROB)
- NREG, 32, number of architectural registers (x0 hard-wired zero)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset; synchronous, active-low (0 = reset)
- rdy_in  in  1  ready; all state holds when low
- flush_pipline  in  1  misprediction flush
- issue_valid  in  1  instruction dispatched this cycle
- issue_rd  in  5  destination reg of dispatched instr
- issue_rob_id  in  ROB_IDX_W  ROB tag of dispatched instr
- q_rs1_valid  in  1  query rs1 this cycle
- q_rs1_id  in  5  rs1 register id
- q_rs2_valid  in  1  query rs2 this cycle
- q_rs2_id  in  5  rs2 register id
- commit_valid  in  1  ROB head commits this cycle
- commit_rd  in  5  committed destination reg
- commit_rob_id  in  ROB_IDX_W  committed ROB tag
- commit_val  in  32  committed result
- rf_rs1_rd_en / rf_rs1_id  out  1/5  register file rs1 read request
- rf_rs2_rd_en / rf_rs2_id  out  1/5  register file rs2 read request
- rf_wr_en / rf_wr_id / rf_wr_val  out  1/5/32  register file write request
- rs1_busy / rs1_rob_id  out  1/ROB_IDX_W  rs1 dependency, valid 1 cycle after query
- rs2_busy / rs2_rob_id  out  1/ROB_IDX_W  rs2 dependency, valid 1 cycle after query
- rs1_fwd_valid / rs1_fwd_val  out  1/32  same-cycle commit forward for rs1
- rs2_fwd_valid / rs2_fwd_val  out  1/32  same-cycle commit forward for rs2

Behaviour:
- State: busy[NREG], tag[NREG][ROB_IDX_W].
- Reset (rst_in=0 at posedge): all busy=0, tags=0, all registered outputs 0.
- rdy_in=0: no state or output changes; the rf_* combinational outputs are forced to 0.
- Read sequencing: rf_rsX_rd_en = q_rsX_valid & rdy_in, rf_rsX_id = q_rsX_id (combinational).
- Query results are registered with 1-cycle latency, matching register file data timing.
  - rsX_busy/rob_id/fwd outputs update only when q_rsX_valid; otherwise they hold.
- Query lookup uses pre-update state of the same cycle. An issue in cycle T to the queried reg is not visible to a query in cycle T.
- Query of x0 always returns busy=0, rob_id=0, fwd_valid=0.
- Commit:
  - rf_wr_en = commit_valid & rdy_in & (commit_rd != 0); rf_wr_id/rf_wr_val pass through combinationally.
  - busy[commit_rd] clears only if tag[commit_rd] == commit_rob_id.
- Issue: if issue_valid and issue_rd != 0, set busy[issue_rd]=1 and tag[issue_rd]=issue_rob_id.
- Issue and commit to the same reg in the same cycle: issue wins (busy=1, new tag).
- flush_pipline=1: all busy cleared next cycle and that cycle's issue is dropped. A same-cycle commit still writes the register file (architectural). Query outputs in the flush cycle are computed normally.
- Flush and reset mid-stream: no pending state survives; the first query after them returns busy=0.

Optional Feature:
Macro REG_DEP_COMMIT_BYPASS_EN.
- Enabled: a query in cycle T whose reg matches a same-cycle commit that would clear it (tag match) returns busy=0 and fwd_valid=1, fwd_val=commit_val. This covers the register file's lack of same-cycle write-to-read forwarding.
- Disabled: fwd_valid is tied 0, and a matching query returns busy=1 with the old tag. The ROB then supplies the value via its own bus.

Decomposition:
- Package reg_dep_pkg: ROB_IDX_W, NREG, REG_ID_W=5, XLEN=32, reg-id and rob-tag typedefs.
- Sub-module reg_dep_lookup, instantiated twice (rs1, rs2):
  - Inputs: table state, query, commit bus.
  - Produces the next-cycle busy/tag/fwd values, including the x0 and bypass logic.

Test Plan:
- Reset, then query x5 -> rs1_busy=0, rs1_rob_id=0 next cycle; rf_rs1_rd_en=1, rf_rs1_id=5 same cycle.
- Issue rd=x5 tag=3, next cycle query x5 -> rs1_busy=1, rs1_rob_id=3. Commit x5 tag=3 val=0xDEAD -> rf_wr_en=1, id=5, val=0xDEAD. Query after that -> busy=0.
- Issue x7 tag=1, issue x7 tag=4, commit x7 tag=1 -> x7 stays busy, tag=4. Same-cycle issue x7 tag=6 with commit x7 tag=4 -> busy=1, tag=6.
- Issue x2 tag=2, query x2 with commit x2 tag=2 val=0x55 in the same cycle:
  - Macro on -> busy=0, fwd_valid=1, fwd_val=0x55.
  - Macro off -> busy=1, tag=2, fwd_valid=0.
- Issue x1, x3, x9 pending, then flush with issue x4 and commit x1 in the same cycle -> rf_wr_en=1 for x1. Next cycle, queries of x1, x3, x4, x9 all return busy=0.
- Issue rd=x0 tag=5 then query x0 -> busy=0; commit rd=x0 -> rf_wr_en=0. With rdy_in=0 during an issue -> no state change and rf_* = 0.
